// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage pipeline: load-use, taken branch, multi-cycle dmem.
// Enables/flushes are Mealy (same cycle); err and perf counters are registered.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem2reg,
    input  logic [4:0]  ex_rd,
    input  logic        me_branch_taken,
    input  logic        me_mem_req,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exme_en,
    output logic        mewb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exme_flush,
    output logic        mewb_flush,
    output logic        err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        load_use;
    logic        mem_stall;
    logic        br_flush;

    assign load_use = ex_mem2reg && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        br_flush     = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exme_en      = 1'b1;
        mewb_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exme_flush   = 1'b0;
        mewb_flush   = 1'b0;

        case (state)
            RUN: begin
                mem_stall = me_mem_req && !dmem_ack;
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 16'd0;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ack) begin
                    mem_stall    = 1'b1;
                    wait_cnt_nxt = wait_cnt + 16'd1;
                    if (wait_cnt == WAIT_LAST)
                        state_nxt = ERR;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = ERR;
            end
        endcase

        // On the ack cycle the RUN priority applies with the memory term already false.
        if (state == ERR) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            exme_en = 1'b0;
            mewb_en = 1'b0;
        end else if (mem_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exme_en    = 1'b0;
            mewb_flush = 1'b1;
        end else if (me_branch_taken) begin
            br_flush   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exme_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end

        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exme_en    = 1'b0;
            mewb_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exme_flush = 1'b1;
            mewb_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= 16'd0;
            err       <= 1'b0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == ERR)
                err <= 1'b1;
            if ((state != ERR) && !pc_en && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (br_flush && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with a short timeout covers ERR.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
    logic        id_uses_rt = 1'b0, ex_mem2reg = 1'b0;
    logic        me_branch_taken = 1'b0, me_mem_req = 1'b0, dmem_ack = 1'b0;

    logic        pc_en, ifid_en, idex_en, exme_en, mewb_en;
    logic        ifid_flush, idex_flush, exme_flush, mewb_flush, err;
    logic [15:0] stall_cnt, flush_cnt;

    logic        pc_en_t, ifid_en_t, idex_en_t, exme_en_t, mewb_en_t;
    logic        ifid_flush_t, idex_flush_t, exme_flush_t, mewb_flush_t, err_t;
    logic [15:0] stall_cnt_t, flush_cnt_t;

    int checks = 0;
    int errors = 0;

    // Control word: {pc,ifid,idex,exme,mewb enables, ifid,idex,exme,mewb flushes}
    localparam logic [8:0] C_RUN   = 9'b11111_0000;
    localparam logic [8:0] C_RST   = 9'b00000_1111;
    localparam logic [8:0] C_LDUSE = 9'b00111_0100;
    localparam logic [8:0] C_BR    = 9'b11111_1110;
    localparam logic [8:0] C_MEM   = 9'b00001_0001;
    localparam logic [8:0] C_ERR   = 9'b00000_0000;

    logic [8:0] ctl, ctl_t;
    assign ctl   = {pc_en, ifid_en, idex_en, exme_en, mewb_en,
                    ifid_flush, idex_flush, exme_flush, mewb_flush};
    assign ctl_t = {pc_en_t, ifid_en_t, idex_en_t, exme_en_t, mewb_en_t,
                    ifid_flush_t, idex_flush_t, exme_flush_t, mewb_flush_t};

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem2reg(ex_mem2reg), .ex_rd(ex_rd), .me_branch_taken(me_branch_taken),
        .me_mem_req(me_mem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exme_en(exme_en), .mewb_en(mewb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exme_flush(exme_flush),
        .mewb_flush(mewb_flush), .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(3)) dut_to (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem2reg(ex_mem2reg), .ex_rd(ex_rd), .me_branch_taken(me_branch_taken),
        .me_mem_req(me_mem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en_t), .ifid_en(ifid_en_t), .idex_en(idex_en_t), .exme_en(exme_en_t),
        .mewb_en(mewb_en_t), .ifid_flush(ifid_flush_t), .idex_flush(idex_flush_t),
        .exme_flush(exme_flush_t), .mewb_flush(mewb_flush_t), .err(err_t),
        .stall_cnt(stall_cnt_t), .flush_cnt(flush_cnt_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 1'b0; ex_mem2reg = 1'b0;
        me_branch_taken = 1'b0; me_mem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset_ctl", 16'(ctl), 16'(C_RST));
        chk("reset_err", 16'(err), 16'd0);
        chk("reset_stall_cnt", stall_cnt, 16'd0);
        chk("reset_flush_cnt", flush_cnt, 16'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("run_idle_ctl", 16'(ctl), 16'(C_RUN));

        // Load-use on rs: exactly one bubble.
        ex_mem2reg = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        #1 chk("lduse_rs_ctl", 16'(ctl), 16'(C_LDUSE));
        tick();
        clear_inputs();
        #1 chk("lduse_rs_after_ctl", 16'(ctl), 16'(C_RUN));
        chk("lduse_rs_stall_cnt", stall_cnt, 16'd1);

        // r0 destination never stalls.
        ex_mem2reg = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        #1 chk("lduse_r0_ctl", 16'(ctl), 16'(C_RUN));
        tick();
        chk("lduse_r0_stall_cnt", stall_cnt, 16'd1);

        // rt match only counts when rt is a source.
        ex_mem2reg = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1 chk("lduse_rt_unused_ctl", 16'(ctl), 16'(C_RUN));
        id_uses_rt = 1'b1;
        #1 chk("lduse_rt_used_ctl", 16'(ctl), 16'(C_LDUSE));
        tick();
        clear_inputs();
        chk("lduse_rt_stall_cnt", stall_cnt, 16'd2);

        // Taken branch.
        me_branch_taken = 1'b1;
        #1 chk("branch_ctl", 16'(ctl), 16'(C_BR));
        tick();
        clear_inputs();
        #1 chk("branch_after_ctl", 16'(ctl), 16'(C_RUN));
        chk("branch_flush_cnt", flush_cnt, 16'd1);
        chk("branch_stall_cnt", stall_cnt, 16'd2);

        // Branch outranks load-use.
        me_branch_taken = 1'b1; ex_mem2reg = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
        #1 chk("branch_over_lduse_ctl", 16'(ctl), 16'(C_BR));
        tick();
        clear_inputs();
        chk("branch_over_lduse_flush_cnt", flush_cnt, 16'd2);

        // Ack in the same cycle as req: no stall.
        me_mem_req = 1'b1; dmem_ack = 1'b1;
        #1 chk("mem_ack_same_ctl", 16'(ctl), 16'(C_RUN));
        tick();
        clear_inputs();
        chk("mem_ack_same_stall_cnt", stall_cnt, 16'd2);

        // Four stall cycles, ack on the fifth.
        me_mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("mem_wait_ctl_%0d", i), 16'(ctl), 16'(C_MEM));
            tick();
        end
        dmem_ack = 1'b1;
        #1 chk("mem_ack_ctl", 16'(ctl), 16'(C_RUN));
        tick();
        clear_inputs();
        chk("mem_wait_stall_cnt", stall_cnt, 16'd6);

        // Branch held through the wait is flushed only on the ack cycle.
        me_mem_req = 1'b1; me_branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("mem_br_wait_ctl_%0d", i), 16'(ctl), 16'(C_MEM));
            tick();
        end
        chk("mem_br_wait_flush_cnt", flush_cnt, 16'd2);
        dmem_ack = 1'b1;
        #1 chk("mem_br_ack_ctl", 16'(ctl), 16'(C_BR));
        tick();
        clear_inputs();
        chk("mem_br_flush_cnt", flush_cnt, 16'd3);
        chk("mem_br_stall_cnt", stall_cnt, 16'd10);

        // Memory stall wins over load-use; load-use re-evaluated on ack.
        me_mem_req = 1'b1; ex_mem2reg = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
        #1 chk("mem_over_lduse_ctl", 16'(ctl), 16'(C_MEM));
        tick();
        dmem_ack = 1'b1;
        #1 chk("mem_ack_lduse_ctl", 16'(ctl), 16'(C_LDUSE));
        tick();
        clear_inputs();
        chk("mem_lduse_stall_cnt", stall_cnt, 16'd12);

        // Timeout with MEM_TIMEOUT=3.
        do_reset();
        chk("to_reset_err", 16'(err_t), 16'd0);
        chk("to_reset_stall_cnt", stall_cnt_t, 16'd0);
        chk("main_reset_flush_cnt", flush_cnt, 16'd0);
        me_mem_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("to_err_edge%0d", i), 16'(err_t), 16'd0);
            chk($sformatf("to_ctl_edge%0d", i), 16'(ctl_t), 16'(C_MEM));
        end
        tick();
        chk("to_err_edge4", 16'(err_t), 16'd1);
        chk("to_ctl_err", 16'(ctl_t), 16'(C_ERR));
        dmem_ack = 1'b1;
        tick();
        chk("to_err_sticky", 16'(err_t), 16'd1);
        chk("to_ctl_err_ack", 16'(ctl_t), 16'(C_ERR));
        chk("to_stall_cnt_frozen", stall_cnt_t, 16'd4);
        chk("main_no_timeout_err", 16'(err), 16'd0);
        // Asynchronous reset out of ERR, mid-cycle.
        #2 rst = 1'b1;
        #1;
        chk("to_rst_err", 16'(err_t), 16'd0);
        chk("to_rst_ctl", 16'(ctl_t), 16'(C_RST));
        chk("to_rst_stall_cnt", stall_cnt_t, 16'd0);
        chk("to_rst_flush_cnt", flush_cnt_t, 16'd0);
        clear_inputs();
        tick();
        rst = 1'b0;
        #1 chk("to_run_after_rst_ctl", 16'(ctl_t), 16'(C_RUN));

        // Stall counter saturation via a held load-use.
        ex_mem2reg = 1'b1; ex_rd = 5'd12; id_rs = 5'd12;
        for (int i = 0; i < 65534; i++) tick();
        chk("sat_stall_cnt_fffe", stall_cnt, 16'hFFFE);
        tick();
        chk("sat_stall_cnt_ffff", stall_cnt, 16'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_stall_cnt_hold", stall_cnt, 16'hFFFF);
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
